// File: rtl/data_memory.sv
// Word-addressed synchronous RAM with registered, write-first read and async-reset contents.
// Optional DATA_MEMORY_PRELOAD_EN: word i resets to i (truncated) instead of 0.
module data_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  write_enable,
    input  logic                  read_enable
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_idx = address[DEPTH_LOG2-1:0];

    // Any set bit above the implemented range makes the access miss instead of aliasing.
    generate
        if (DEPTH_LOG2 < ADDR_WIDTH) begin : g_range
            assign w_in_range = ~|address[ADDR_WIDTH-1:DEPTH_LOG2];
        end else begin : g_full
            assign w_in_range = 1'b1;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef DATA_MEMORY_PRELOAD_EN
                r_mem[i] <= DATA_WIDTH'(i);
`else
                r_mem[i] <= '0;
`endif
            end
        end else if (write_enable && w_in_range) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // A single address port means a same-cycle read and write always target the same word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if (read_enable) begin
            if (!w_in_range)
                r_data_out <= '0;
            else if (write_enable)
                r_data_out <= data_in;
            else
                r_data_out <= r_mem[w_idx];
        end
    end

    assign data_out = r_data_out;
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expected values follow DATA_MEMORY_PRELOAD_EN.
module tb_data_memory;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        write_enable;
    logic        read_enable;
    int          passed = 0;
    int          total = 0;

    data_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(8)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
        .data_out(data_out), .write_enable(write_enable), .read_enable(read_enable)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] rv(input int i);
`ifdef DATA_MEMORY_PRELOAD_EN
        return 16'(i);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [15:0] a, input logic [15:0] d);
        write_enable = we; read_enable = re; address = a; data_in = d;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        reset_n = 1'b0;
        #1;
        total++;
        if (data_out !== 16'h0) $display("FAIL reset_before_clock got %h want 0000", data_out); else passed++;
        tick(); tick();
        total++;
        if (data_out !== 16'h0) $display("FAIL reset_hold got %h want 0000", data_out); else passed++;
        #4 reset_n = 1'b1;
    endtask

    task automatic test_read_after_reset();
        drive(1'b0, 1'b1, 16'd1, 16'h0);
        tick();
        total++;
        if (data_out !== rv(1)) $display("FAIL read_after_reset got %h want %h", data_out, rv(1)); else passed++;
        drive(1'b0, 1'b1, 16'h00FF, 16'h0);
        tick();
        total++;
        if (data_out !== rv(255)) $display("FAIL read_top_word got %h want %h", data_out, rv(255)); else passed++;
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 16'd1, 16'h0);
        tick();
        drive(1'b1, 1'b0, 16'd1, 16'd16);
        tick();
        total++;
        if (data_out !== rv(1)) $display("FAIL hold_during_write got %h want %h", data_out, rv(1)); else passed++;
        drive(1'b0, 1'b1, 16'd1, 16'h0);
        tick();
        total++;
        if (data_out !== 16'd16) $display("FAIL write_then_read got %h want 0010", data_out); else passed++;
    endtask

    task automatic test_write_first();
        drive(1'b1, 1'b1, 16'd5, 16'hABCD);
        tick();
        total++;
        if (data_out !== 16'hABCD) $display("FAIL write_first got %h want abcd", data_out); else passed++;
        drive(1'b0, 1'b1, 16'd5, 16'h0);
        tick();
        total++;
        if (data_out !== 16'hABCD) $display("FAIL write_first_readback got %h want abcd", data_out); else passed++;
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b0, 16'h0101, 16'h1234);
        tick();
        drive(1'b0, 1'b1, 16'h0001, 16'h0);
        tick();
        total++;
        if (data_out !== 16'd16) $display("FAIL oor_no_alias got %h want 0010", data_out); else passed++;
        drive(1'b0, 1'b1, 16'h0101, 16'h0);
        tick();
        total++;
        if (data_out !== 16'h0) $display("FAIL oor_read got %h want 0000", data_out); else passed++;
        drive(1'b0, 1'b1, 16'h0001, 16'h0);
        tick();
        drive(1'b1, 1'b1, 16'h8001, 16'h7777);
        tick();
        total++;
        if (data_out !== 16'h0) $display("FAIL oor_read_write got %h want 0000", data_out); else passed++;
        drive(1'b0, 1'b1, 16'h0001, 16'h0);
        tick();
        total++;
        if (data_out !== 16'd16) $display("FAIL oor_msb_no_alias got %h want 0010", data_out); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'(10 + i), 16'(16'hC000 + i * 16'h0111));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 16'(10 + i), 16'h0);
            tick();
            total++;
            if (data_out !== 16'(16'hC000 + i * 16'h0111))
                $display("FAIL back_to_back[%0d] got %h want %h", i, data_out, 16'(16'hC000 + i * 16'h0111));
            else passed++;
        end
    endtask

    task automatic test_hold_and_glitch();
        drive(1'b0, 1'b0, 16'd5, 16'h0);
        #2 address = 16'd1;
        tick();
        total++;
        if (data_out !== 16'hC333) $display("FAIL hold_no_read got %h want c333", data_out); else passed++;
        // Write strobe pulsed entirely between edges must not reach the array.
        #2 drive(1'b1, 1'b0, 16'd20, 16'hDEAD);
        #2 drive(1'b0, 1'b0, 16'd20, 16'h0);
        tick();
        drive(1'b0, 1'b1, 16'd20, 16'h0);
        tick();
        total++;
        if (data_out !== rv(20)) $display("FAIL between_edge_glitch got %h want %h", data_out, rv(20)); else passed++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 16'd3, 16'h00FF);
        tick();
        drive(1'b0, 1'b1, 16'd3, 16'h0);
        tick();
        total++;
        if (data_out !== 16'h00FF) $display("FAIL pre_reset_read got %h want 00ff", data_out); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (data_out !== 16'h0) $display("FAIL async_reset got %h want 0000", data_out); else passed++;
        drive(1'b1, 1'b1, 16'd7, 16'h5555);
        tick(); tick();
        total++;
        if (data_out !== 16'h0) $display("FAIL reset_ignores_access got %h want 0000", data_out); else passed++;
        drive(1'b0, 1'b0, 16'd0, 16'h0);
        #4 reset_n = 1'b1;
        drive(1'b0, 1'b1, 16'd3, 16'h0);
        tick();
        total++;
        if (data_out !== rv(3)) $display("FAIL read_after_async_reset got %h want %h", data_out, rv(3)); else passed++;
        drive(1'b0, 1'b1, 16'd5, 16'h0);
        tick();
        total++;
        if (data_out !== rv(5)) $display("FAIL word5_reset got %h want %h", data_out, rv(5)); else passed++;
        drive(1'b0, 1'b1, 16'd7, 16'h0);
        tick();
        total++;
        if (data_out !== rv(7)) $display("FAIL reset_write_ignored got %h want %h", data_out, rv(7)); else passed++;
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_write_first();
        test_out_of_range();
        test_back_to_back();
        test_hold_and_glitch();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
